// File: rtl/ram_bist_engine.sv
// ram_bist_engine: block-RAM self-test engine.
// Owns a DATA_W x 2^ADDR_W single-clock RAM. Each pass writes a deterministic
// pattern to every word, then reads every word back and compares it. Odd
// passes use the inverted pattern. Reports pass/fail, a saturating error
// count and the first failing location. inject_err corrupts one pass-0 write
// so the fail path can be exercised on the board.
//
// Ports:
//   hw_clk, hw_rst_n  clock, asynchronous active-low reset
//   start             run request, sampled only in IDLE
//   inject_err        sampled with an accepted start; flips bit0 of the
//                     pass-0 write at address 3
//   busy              test in progress
//   done, pass        sticky completion flag and result (pass valid when done)
//   err_cnt           mismatch count, saturates at 16'hFFFF
//   fail_addr/data    address and read data of the first mismatch
//   led               fast blink while busy, on for pass, slow blink for fail
module ram_bist_engine #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 8,
  parameter int unsigned SEED    = 32'hA5,
  parameter int          PASSES  = 2,
  parameter int          BLINK_W = 24
) (
  input  logic              hw_clk,
  input  logic              hw_rst_n,
  input  logic              start,
  input  logic              inject_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              led
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] SEED_W    = DATA_W'(SEED);
  localparam logic [3:0]        LAST_PASS = 4'(PASSES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] INJ_ADDR  = ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        k_q, k_d;
  logic              inj_q, inj_d;
  logic              accept, finish;

  // Expected word for a pass parity and address.
  function automatic logic [DATA_W-1:0] pattern(input logic odd,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = DATA_W'(a) + SEED_W;
    return odd ? ~p : p;
  endfunction

  // ---------------------------------------------------------------- FSM
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    k_d     = k_q;
    inj_d   = inj_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          inj_d   = inject_err;
          k_d     = '0;
          addr_d  = '0;
          state_d = WR;
        end
      end
      WR: begin
        addr_d = addr_q + ADDR_W'(1);   // wraps to 0 after the last word
        if (addr_q == LAST_ADDR) state_d = RD;
      end
      RD: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        addr_d = '0;
        if (k_q < LAST_PASS) begin
          k_d     = k_q + 4'd1;
          state_d = WR;
        end else begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge hw_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      k_q     <= '0;
      inj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      inj_q   <= inj_d;
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------- RAM
  logic              we, rd_en, corrupt;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [DATA_W-1:0] mem [DEPTH];

  assign we      = (state_q == WR);
  assign rd_en   = (state_q == RD);
  assign corrupt = inj_q && (k_q == 4'd0) && (addr_q == INJ_ADDR);
  assign wr_data = pattern(k_q[0], addr_q) ^ DATA_W'(corrupt);

  // NOTE: the array and its read register carry no reset so the tools can map
  // them onto a block RAM; the compare pipeline below qualifies rd_data.
  always_ff @(posedge hw_clk) begin
    if (we)    mem[addr_q] <= wr_data;
    if (rd_en) rd_data     <= mem[addr_q];
  end

  // ---------------------------------------------------------------- compare
  // Expected word and address travel one stage alongside the RAM read.
  logic              cmp_valid_q, mismatch;
  logic [DATA_W-1:0] exp_q, cmp_data;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [15:0]       err_cnt_d;

  always_ff @(posedge hw_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      cmp_valid_q <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
    end else begin
      cmp_valid_q <= rd_en;
      exp_q       <= pattern(k_q[0], addr_q);
      cmp_addr_q  <= addr_q;
    end
  end

  assign cmp_data  = rd_data;
  assign mismatch  = cmp_valid_q && (cmp_data != exp_q);
  assign err_cnt_d = (mismatch && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;

  // err_cnt never returns to zero within a run, so zero marks the first miss.
  always_ff @(posedge hw_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (accept) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      err_cnt <= err_cnt_d;
      if (mismatch && err_cnt == 16'd0) begin
        fail_addr <= cmp_addr_q;
        fail_data <= cmp_data;
      end
      if (finish) begin
        done <= 1'b1;
        pass <= (err_cnt_d == 16'd0);   // includes the compare done in DRAIN
      end
    end
  end

  // ---------------------------------------------------------------- LED
  logic [BLINK_W-1:0] blink_q;

  always_ff @(posedge hw_clk or negedge hw_rst_n) begin
    if (!hw_rst_n) blink_q <= '0;
    else           blink_q <= blink_q + BLINK_W'(1);
  end

  always_comb begin
    led = 1'b0;
    if (busy)              led = blink_q[BLINK_W-5];
    else if (done && pass) led = 1'b1;
    else if (done)         led = blink_q[BLINK_W-1];
  end

endmodule

// File: tb/tb_ram_bist_engine.sv
`timescale 1ns/1ps
// Testbench for ram_bist_engine: default-size instance plus a small
// ADDR_W=4, SEED=0 instance with a write-port monitor.
module tb_ram_bist_engine;

  localparam int          DATA_W     = 8;
  localparam int          ADDR_W     = 8;
  localparam int unsigned SEED       = 32'hA5;
  localparam int          PASSES     = 2;
  localparam int          BLINK_W    = 24;
  localparam int          DEPTH      = 1 << ADDR_W;
  localparam int          RUN_CYCLES = PASSES * (2 * DEPTH + 1);
  localparam int          S_ADDR_W   = 4;
  localparam int          S_DEPTH    = 1 << S_ADDR_W;
  localparam int          S_BLINK_W  = 6;
  localparam int          S_CYCLES   = PASSES * (2 * S_DEPTH + 1);
  localparam int          RUN_LIMIT  = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, inject = 1'b0;
  logic start_s = 1'b0, inject_s = 1'b0;

  logic              busy, done, pass, led;
  logic [15:0]       err_cnt;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  logic                busy_s, done_s, pass_s, led_s;
  logic [15:0]         err_cnt_s;
  logic [S_ADDR_W-1:0] fail_addr_s;
  logic [DATA_W-1:0]   fail_data_s;

  int checks = 0;
  int failures = 0;
  int unsigned cyc;   // clock edges since reset release
  logic [11:0] wr_log[$];

  always #5 clk = ~clk;

  ram_bist_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEED(SEED),
                    .PASSES(PASSES), .BLINK_W(BLINK_W)) dut (
    .hw_clk(clk), .hw_rst_n(rst_n), .start(start), .inject_err(inject),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data), .led(led));

  ram_bist_engine #(.DATA_W(DATA_W), .ADDR_W(S_ADDR_W), .SEED(0),
                    .PASSES(PASSES), .BLINK_W(S_BLINK_W)) dut_s (
    .hw_clk(clk), .hw_rst_n(rst_n), .start(start_s), .inject_err(inject_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s),
    .fail_addr(fail_addr_s), .fail_data(fail_data_s), .led(led_s));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Write-port monitor on the small instance: a write commits at the next edge.
  always @(negedge clk) begin
    if (rst_n && dut_s.we) wr_log.push_back({dut_s.addr_q, dut_s.wr_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int exp_word(input int k, input int a, input int seed);
    int p;
    p = (a + seed) % (1 << DATA_W);
    if (k % 2 == 1) p = p ^ ((1 << DATA_W) - 1);
    return p;
  endfunction

  // Whole-run outcome: write all words, read them back, count mismatches.
  // frc models a read path that always returns the inverse of the expected word.
  function automatic void model_run(input int depth, input int seed, input bit inj,
                                    input bit frc, output int err, output int faddr,
                                    output int fdata);
    int mem [256];
    int w, e, got;
    err = 0; faddr = 0; fdata = 0;
    for (int k = 0; k < PASSES; k++) begin
      for (int a = 0; a < depth; a++) begin
        w = exp_word(k, a, seed);
        if (inj && k == 0 && a == 3) w = w ^ 1;
        mem[a] = w;
      end
      for (int a = 0; a < depth; a++) begin
        e   = exp_word(k, a, seed);
        got = frc ? (e ^ ((1 << DATA_W) - 1)) : mem[a];
        if (got != e) begin
          if (err == 0) begin faddr = a; fdata = got; end
          if (err < 65535) err++;
        end
      end
    end
  endfunction

  // ---------------------------------------------------------------- tasks
  task automatic run_main(input bit inj, input bit glitch, input bit frc,
                          input bit sat, output int cycles);
    start = 1'b1; inject = inj;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_done_clr", done, 0);
    check("accept_pass_clr", pass, 0);
    cycles = 0;
    while (busy && cycles < RUN_LIMIT) begin
      cycles++;
      if (glitch) begin
        start  = 1'($urandom_range(0, 1));
        inject = 1'($urandom_range(0, 1));
      end
      if (frc) force dut.cmp_data = ~dut.exp_q;
      if (sat && cycles == 300) force dut.err_cnt = 16'hFFFF;
      if (sat && cycles == 301) release dut.err_cnt;
      if (sat && cycles == 320) check("sat_hold", err_cnt, 16'hFFFF);
      @(negedge clk);
    end
    start = 1'b0;
    if (frc) release dut.cmp_data;
  endtask

  task automatic end_checks(input string tag, input int cycles, input bit exp_pass,
                            input int exp_err, input int exp_fa, input int exp_fd);
    check({tag, "_cycles"}, cycles, RUN_CYCLES);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_fail_addr"}, fail_addr, exp_fa);
    check({tag, "_fail_data"}, fail_data, exp_fd);
    check({tag, "_led"}, led, exp_pass ? 1'b1 : cyc[BLINK_W-1]);
  endtask

  task automatic run_small(input bit inj);
    int cycles, err, fa, fd, w;
    logic [11:0] exp_log[$];
    wr_log.delete();
    start_s = 1'b1; inject_s = inj;
    @(negedge clk);
    start_s = 1'b0; inject_s = ~inj;   // later changes must be ignored
    cycles = 0;
    while (busy_s && cycles < RUN_LIMIT) begin
      cycles++;
      if (cycles == 10 || cycles == 23) check("s_led_busy", led_s, cyc[S_BLINK_W-5]);
      @(negedge clk);
    end
    inject_s = 1'b0;
    model_run(S_DEPTH, 0, inj, 1'b0, err, fa, fd);
    check("s_cycles", cycles, S_CYCLES);
    check("s_done", done_s, 1);
    check("s_pass", pass_s, err == 0);
    check("s_err_cnt", err_cnt_s, err);
    check("s_fail_addr", fail_addr_s, fa);
    check("s_fail_data", fail_data_s, fd);
    for (int k = 0; k < PASSES; k++) begin
      for (int a = 0; a < S_DEPTH; a++) begin
        w = exp_word(k, a, 0);
        if (inj && k == 0 && a == 3) w = w ^ 1;
        exp_log.push_back({4'(a), 8'(w)});
      end
    end
    check("s_wr_count", wr_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < wr_log.size()) check("s_wr_word", wr_log[i], exp_log[i]);
    end
    for (int i = 0; i < 8; i++) begin
      repeat (5) @(negedge clk);
      check("s_led_idle", led_s, (err == 0) ? 1'b1 : cyc[S_BLINK_W-1]);
    end
  endtask

  // ---------------------------------------------------------------- test
  typedef struct {
    bit inj;
    bit glitch;
    bit exp_pass;
    int exp_err;
    int exp_fa;
    int exp_fd;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cycles, err, fa, fd;
    bit inj;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1, 3, 'hA9};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1, 3, 'hA9};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 0, 0, 0};

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_data", fail_data, 0);
    check("rst_led", led, 0);
    check("rst_s_busy", busy_s, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_main(vecs[i].inj, vecs[i].glitch, 1'b0, 1'b0, cycles);
      end_checks("vec", cycles, vecs[i].exp_pass, vecs[i].exp_err, vecs[i].exp_fa, vecs[i].exp_fd);
    end

    // Randomised runs against the model
    for (int i = 0; i < 3; i++) begin
      inj = 1'($urandom_range(0, 1));
      run_main(inj, 1'b1, 1'b0, 1'b0, cycles);
      model_run(DEPTH, int'(SEED), inj, 1'b0, err, fa, fd);
      end_checks("rand", cycles, err == 0, err, fa, fd);
    end

    // Read path forced to mismatch every word
    run_main(1'b0, 1'b0, 1'b1, 1'b0, cycles);
    model_run(DEPTH, int'(SEED), 1'b0, 1'b1, err, fa, fd);
    end_checks("allbad", cycles, 1'b0, err, fa, fd);

    // Counter forced to its ceiling mid-run must stay there
    run_main(1'b0, 1'b0, 1'b1, 1'b1, cycles);
    end_checks("sat", cycles, 1'b0, 16'hFFFF, fa, fd);

    // Reset in the middle of a failing run
    start = 1'b1; inject = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_err_cnt", err_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pass", pass, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_fail_addr", fail_addr, 0);
    check("mid_rst_fail_data", fail_data, 0);
    check("mid_rst_led", led, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 0);
    run_main(1'b0, 1'b0, 1'b0, 1'b0, cycles);
    end_checks("post_rst", cycles, 1'b1, 0, 0, 0);

    // Small instance: write-port contents, fail then pass
    run_small(1'b1);
    run_small(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
